// File: rtl/fft_bitrev_feeder.sv
// Frame buffer for the 32-point FFT sorting stage: collects N samples in natural
// order, then replays them as one gap-free burst in bit-reversed index order.
module fft_bitrev_feeder #(
  parameter int DATA_W = 16,
  parameter int N      = 32,
  parameter int LOG2N  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_r,
  input  logic [DATA_W-1:0] i_in_i,
  output logic              o_start_sorting,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_r,
  output logic [DATA_W-1:0] o_out_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [LOG2N-1:0]  r_wr_cnt;
  logic [LOG2N-1:0]  r_rd_cnt;
  logic [LOG2N-1:0]  w_rd_addr;
  logic [DATA_W-1:0] r_mem_r [N];
  logic [DATA_W-1:0] r_mem_i [N];
  logic              w_ready;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_first_rd;
  logic              r_out_valid;
  logic              r_start;
  logic [DATA_W-1:0] r_out_r;
  logic [DATA_W-1:0] r_out_i;

  // Read address is the drain counter with its bit order mirrored.
  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_bitrev
      assign w_rd_addr[gi] = r_rd_cnt[LOG2N-1-gi];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    w_rd_en      = 1'b0;
    w_first_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = i_rst;
        if (i_in_valid && i_rst) w_state_next = S_FILL;
      end
      S_FILL: begin
        w_ready = i_rst;
        if (i_in_valid && i_rst && (r_wr_cnt == LOG2N'(N-1))) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_rd_en    = 1'b1;
        w_first_rd = (r_rd_cnt == '0);
        if (r_rd_cnt == LOG2N'(N-1)) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept   = i_in_valid & w_ready;
  assign o_in_ready = w_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_valid <= 1'b0;
      r_start     <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
    end else begin
      if (w_accept) r_wr_cnt <= r_wr_cnt + LOG2N'(1);
      // Output data holds its last word whenever no read is issued.
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + LOG2N'(1);
        r_out_r  <= r_mem_r[w_rd_addr];
        r_out_i  <= r_mem_i[w_rd_addr];
      end
      r_out_valid <= w_rd_en;
      r_start     <= w_first_rd;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_mem_r[r_wr_cnt] <= i_in_r;
      r_mem_i[r_wr_cnt] <= i_in_i;
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_start_sorting = r_start;
  assign o_out_r         = r_out_r;
  assign o_out_i         = r_out_i;

endmodule

// File: tb/tb_fft_bitrev_feeder.sv
// Bench for fft_bitrev_feeder: frames are pushed through the input handshake and
// each burst is compared with a bit-reversal / sorting-stage model.
module tb_fft_bitrev_feeder;
  localparam int DW = 16;
  localparam int N  = 32;
  localparam int LG = 5;

  logic          clk = 1'b0;
  logic          i_rst, i_in_valid, o_in_ready, o_start_sorting, o_out_valid;
  logic [DW-1:0] i_in_r, i_in_i, o_out_r, o_out_i;

  always #5 clk = ~clk;

  fft_bitrev_feeder #(.DATA_W(DW), .N(N), .LOG2N(LG)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_in_r(i_in_r), .i_in_i(i_in_i), .o_start_sorting(o_start_sorting),
    .o_out_valid(o_out_valid), .o_out_r(o_out_r), .o_out_i(o_out_i)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] fr_r [N];
  logic [DW-1:0] fr_i [N];
  logic [DW-1:0] cap_r [$];
  logic [DW-1:0] cap_i [$];
  int            cap_first, cap_start_idx, cap_starts, cap_ready_low;
  bit            cap_gap, cap_ready_end;

  // Mirror an index over LG bits by peeling binary digits arithmetically.
  function automatic int bitrev(input int k);
    int r = 0;
    int v = k;
    for (int b = 0; b < LG; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      fr_r[k] = DW'(k);
      fr_i[k] = DW'(-k);
    end
  endtask

  // mode>0: in_valid high every mode-th cycle; mode<0: random in_valid.
  task automatic send_frame(input int mode);
    int idx = 0;
    int cyc = 0;
    bit acc;
    @(posedge clk); #1;
    while (idx < N && cyc < 2000) begin
      if (mode < 0) i_in_valid = 1'($urandom_range(0, 1));
      else          i_in_valid = ((cyc % mode) == 0);
      i_in_r = fr_r[idx];
      i_in_i = fr_i[idx];
      @(negedge clk);
      acc = i_in_valid && o_in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    i_in_valid = 1'b0;
    n_tests++;
    if (idx != N) begin
      n_fail++;
      $display("FAIL send_frame: accepted %0d samples, required %0d", idx, N);
    end
  endtask

  // Starts right after the edge that accepted the last sample; index j is the
  // negedge following that edge + j.
  task automatic collect(input int ncyc);
    int last = -1;
    cap_r.delete(); cap_i.delete();
    cap_first = -1; cap_start_idx = -1; cap_starts = 0; cap_ready_low = 0;
    cap_gap = 1'b0; cap_ready_end = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      if (o_out_valid) begin
        if (cap_first < 0) cap_first = j;
        else if (last != j - 1) cap_gap = 1'b1;
        last = j;
        cap_r.push_back(o_out_r);
        cap_i.push_back(o_out_i);
      end
      if (o_start_sorting) begin
        cap_starts++;
        if (cap_start_idx < 0) cap_start_idx = j;
      end
      if (!o_in_ready) cap_ready_low++;
      if (cap_first >= 0 && j == cap_first + N - 1) cap_ready_end = o_in_ready;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (o_out_valid !== 1'b0 || o_start_sorting !== 1'b0 || o_out_r !== '0 ||
          o_out_i !== '0 || o_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b start=%b r=%h i=%h ready=%b, required 0 0 0 0 0",
                 o_out_valid, o_start_sorting, o_out_r, o_out_i, o_in_ready);
      end
    end
    @(posedge clk); #1 i_rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b valid=%b, required 1 0", o_in_ready, o_out_valid);
    end
  endtask

  task automatic test_ramp();
    fill_ramp();
    send_frame(1);
    collect(40);
    n_tests++;
    if (cap_first !== 1 || cap_r.size() != N || cap_gap) begin
      n_fail++;
      $display("FAIL ramp_shape: first=%0d words=%0d gap=%0d, required 1 %0d 0",
               cap_first, cap_r.size(), cap_gap, N);
    end
    n_tests++;
    if (cap_starts != 1 || cap_start_idx != 1) begin
      n_fail++;
      $display("FAIL ramp_start: pulses=%0d at=%0d, required 1 at 1", cap_starts, cap_start_idx);
    end
    n_tests++;
    if (cap_ready_low != N || cap_ready_end !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_ready: low cycles=%0d ready_after=%b, required %0d 1",
               cap_ready_low, cap_ready_end, N);
    end
    for (int k = 0; k < N && k < cap_r.size(); k++) begin
      n_tests++;
      if (cap_r[k] !== DW'(bitrev(k)) || cap_i[k] !== DW'(-bitrev(k))) begin
        n_fail++;
        $display("FAIL ramp_word%0d: got %h/%h required %h/%h", k, cap_r[k], cap_i[k],
                 DW'(bitrev(k)), DW'(-bitrev(k)));
      end
    end
  endtask

  task automatic test_bubbles();
    fill_ramp();
    send_frame(3);
    collect(40);
    n_tests++;
    if (cap_first !== 1 || cap_r.size() != N || cap_gap || cap_starts != 1) begin
      n_fail++;
      $display("FAIL bubbles_shape: first=%0d words=%0d gap=%0d starts=%0d, required 1 %0d 0 1",
               cap_first, cap_r.size(), cap_gap, cap_starts, N);
    end
    for (int k = 0; k < N && k < cap_r.size(); k++) begin
      n_tests++;
      if (cap_r[k] !== DW'(bitrev(k)) || cap_i[k] !== DW'(-bitrev(k))) begin
        n_fail++;
        $display("FAIL bubbles_word%0d: got %h/%h required %h/%h", k, cap_r[k], cap_i[k],
                 DW'(bitrev(k)), DW'(-bitrev(k)));
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_ramp();
    send_frame(1);
    for (int k = 0; k < N; k++) begin
      fr_r[k] = 16'h7FFF - DW'(k);
      fr_i[k] = 16'h8000 + DW'(k);
    end
    fork
      collect(40);
      send_frame(1);
    join
    n_tests++;
    if (cap_r.size() != N || cap_gap || cap_ready_low != N) begin
      n_fail++;
      $display("FAIL b2b_a_shape: words=%0d gap=%0d ready_low=%0d, required %0d 0 %0d",
               cap_r.size(), cap_gap, cap_ready_low, N, N);
    end
    for (int k = 0; k < N && k < cap_r.size(); k++) begin
      n_tests++;
      if (cap_r[k] !== DW'(bitrev(k)) || cap_i[k] !== DW'(-bitrev(k))) begin
        n_fail++;
        $display("FAIL b2b_a_word%0d: got %h/%h required %h/%h", k, cap_r[k], cap_i[k],
                 DW'(bitrev(k)), DW'(-bitrev(k)));
      end
    end
    collect(40);
    n_tests++;
    if (cap_first !== 1 || cap_r.size() != N || cap_gap || cap_starts != 1) begin
      n_fail++;
      $display("FAIL b2b_b_shape: first=%0d words=%0d gap=%0d starts=%0d, required 1 %0d 0 1",
               cap_first, cap_r.size(), cap_gap, cap_starts, N);
    end
    for (int k = 0; k < N && k < cap_r.size(); k++) begin
      n_tests++;
      if (cap_r[k] !== 16'h7FFF - DW'(bitrev(k)) || cap_i[k] !== 16'h8000 + DW'(bitrev(k))) begin
        n_fail++;
        $display("FAIL b2b_b_word%0d: got %h/%h required %h/%h", k, cap_r[k], cap_i[k],
                 16'h7FFF - DW'(bitrev(k)), 16'h8000 + DW'(bitrev(k)));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit bad = 1'b0;
    fill_ramp();
    send_frame(1);
    repeat (11) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_out_valid !== 1'b1 || o_out_r !== DW'(bitrev(10)) || o_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_word10: valid=%b r=%h ready=%b, required 1 %h 0",
               o_out_valid, o_out_r, o_in_ready, DW'(bitrev(10)));
    end
    @(posedge clk); #1 i_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_out_valid !== 1'b0 || o_start_sorting !== 1'b0 || o_out_r !== '0 ||
          o_out_i !== '0 || o_in_ready !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL midrst_abort: burst words or non-reset outputs after reset, required valid=0 data=0 ready=1");
    end
    send_frame(1);
    collect(40);
    n_tests++;
    if (cap_first !== 1 || cap_r.size() != N || cap_gap || cap_starts != 1) begin
      n_fail++;
      $display("FAIL midrst_next_shape: first=%0d words=%0d gap=%0d starts=%0d, required 1 %0d 0 1",
               cap_first, cap_r.size(), cap_gap, cap_starts, N);
    end
    for (int k = 0; k < N && k < cap_r.size(); k++) begin
      n_tests++;
      if (cap_r[k] !== DW'(bitrev(k)) || cap_i[k] !== DW'(-bitrev(k))) begin
        n_fail++;
        $display("FAIL midrst_next_word%0d: got %h/%h required %h/%h", k, cap_r[k], cap_i[k],
                 DW'(bitrev(k)), DW'(-bitrev(k)));
      end
    end
  endtask

  // Sorting-stage model: burst position j holds natural index bitrev(j).
  task automatic test_loopback();
    logic [DW-1:0] nat_r [N];
    logic [DW-1:0] nat_i [N];
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) begin
        fr_r[k] = DW'($urandom);
        fr_i[k] = DW'($urandom);
      end
      send_frame(-1);
      collect(40);
      n_tests++;
      if (cap_r.size() != N || cap_gap || cap_starts != 1) begin
        n_fail++;
        $display("FAIL loop%0d_shape: words=%0d gap=%0d starts=%0d, required %0d 0 1",
                 f, cap_r.size(), cap_gap, cap_starts, N);
      end else begin
        for (int j = 0; j < N; j++) begin
          nat_r[bitrev(j)] = cap_r[j];
          nat_i[bitrev(j)] = cap_i[j];
        end
        for (int k = 0; k < N; k++) begin
          n_tests++;
          if (nat_r[k] !== fr_r[k] || nat_i[k] !== fr_i[k]) begin
            n_fail++;
            $display("FAIL loop%0d_sample%0d: got %h/%h required %h/%h",
                     f, k, nat_r[k], nat_i[k], fr_r[k], fr_i[k]);
          end
        end
      end
    end
  endtask

  initial begin
    i_rst = 1'b0; i_in_valid = 1'b0; i_in_r = '0; i_in_i = '0;
    test_reset();
    test_ramp();
    test_bubbles();
    test_back_to_back();
    test_reset_mid_burst();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
